// File: rtl/jpeg_zigzag_buffer.sv
// Raster-to-zigzag reorder buffer between the quantizer and the run-length encoder.
// Ping-pong 64-entry banks; one registered output stage, one coefficient per clock sustained.
module jpeg_zigzag_buffer #(
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob,
  input  logic              out_ready
);

  // Raster address for each zigzag index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DWIDTH-1:0] bank [2][64];
  logic              wr_bank;
  logic              rd_bank;
  logic [5:0]        wr_idx;
  logic [5:0]        rd_idx;
  logic [1:0]        full;
  logic              wr_en;
  logic              rd_load;

  assign in_ready = !rst && !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign rd_load  = full[rd_bank] && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[wr_bank][wr_idx] <= in_data;
    end
  end

  // A set and a clear of full[] in the same cycle always hit different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= 6'd0;
      rd_idx    <= 6'd0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_idx <= wr_idx + 6'd1;
        if (wr_idx == 6'd63) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_load) begin
        out_data  <= bank[rd_bank][ZZ[rd_idx]];
        out_valid <= 1'b1;
        out_sob   <= (rd_idx == 6'd0);
        out_eob   <= (rd_idx == 6'd63);
        rd_idx    <= rd_idx + 6'd1;
        if (rd_idx == 6'd63) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_zigzag_buffer.sv
// Bench for jpeg_zigzag_buffer: random stimulus against a block-level zigzag reference model.
module tb_jpeg_zigzag_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_sob;
  logic        out_eob;
  logic        out_ready = 1'b0;

  jpeg_zigzag_buffer #(.DWIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob), .out_eob(out_eob),
    .out_ready(out_ready)
  );

  always #5 clk = !clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic        e;
    int          c;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        obs_q[$];
  int          zz[64];
  logic [11:0] blk[64];
  int          cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          acc_cnt = 0;
  int          stalls = 0;

  // Walk the anti-diagonals of the 8x8 block, alternating direction.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  // Drive one cycle from a negedge; record accepted inputs into the model and observed outputs.
  task automatic step(input logic iv, input logic [11:0] d, input logic ordy);
    ent_t o;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (iv && !rst && in_ready === 1'b1) begin
      blk[cnt] = d; cnt++; acc_cnt++; last_acc = cyc;
      if (cnt == 64) begin
        for (int k = 0; k < 64; k++) begin
          ent_t e;
          e.d = blk[zz[k]]; e.s = (k == 0); e.e = (k == 63); e.c = 0;
          exp_q.push_back(e);
        end
        cnt = 0;
      end
    end
    if (iv && !rst && in_ready !== 1'b1) stalls++;
    if (!rst && ordy && out_valid === 1'b1) begin
      o.d = out_data; o.s = out_sob; o.e = out_eob; o.c = cyc;
      obs_q.push_back(o);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) step(1'b0, 12'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 12'hABC, 1'b1);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: in_ready=%b out_valid=%b, want 0 0", i, in_ready, out_valid);
      end
    end
    vectors++;
    if (out_data !== 12'd0 || out_sob !== 1'b0 || out_eob !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=%0d sob=%b eob=%b, want 0 0 0", out_data, out_sob, out_eob);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
    cnt = 0; exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zigzag();
    ent_t o, e;
    int first_c, acc_c;
    for (int i = 0; i < 64; i++) step(1'b1, 12'(i), 1'b1);
    acc_c = last_acc;
    drain(64, 200);
    vectors++;
    if (obs_q.size() != 64) begin
      miscompares++;
      $display("FAIL zigzag_count: got %0d outputs, want 64", obs_q.size());
    end
    // Accepted at the edge closing cycle acc_c, loaded one edge later, visible in acc_c+2.
    first_c = (obs_q.size() > 0) ? obs_q[0].c : -1;
    vectors++;
    if (first_c != acc_c + 2) begin
      miscompares++;
      $display("FAIL zigzag_latency: first output cycle %0d, want %0d", first_c, acc_c + 2);
    end
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e || o.d !== 12'(zz[k])) begin
        miscompares++;
        $display("FAIL zigzag[%0d]: got d=%0d sob=%b eob=%b, want d=%0d sob=%b eob=%b",
                 k, o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t o, e;
    int c0;
    stalls = 0;
    for (int i = 0; i < 256; i++) step(1'b1, 12'($urandom), 1'b1);
    vectors++;
    if (stalls != 0) begin
      miscompares++;
      $display("FAIL stream_in_ready: %0d stalled input cycles, want 0", stalls);
    end
    drain(256, 300);
    vectors++;
    if (obs_q.size() != 256) begin
      miscompares++;
      $display("FAIL stream_count: got %0d outputs, want 256", obs_q.size());
    end
    c0 = (obs_q.size() > 0) ? obs_q[0].c : 0;
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e || o.c != c0 + k) begin
        miscompares++;
        $display("FAIL stream[%0d]: got d=%0d sob=%b eob=%b cyc=%0d, want d=%0d sob=%b eob=%b cyc=%0d",
                 k, o.d, o.s, o.e, o.c, e.d, e.s, e.e, c0 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    ent_t o, e;
    int base = acc_cnt;
    for (int i = 0; i < 192; i++) step(1'b1, 12'(acc_cnt - base), 1'b0);
    vectors++;
    if (acc_cnt - base != 128 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_fill: accepted=%0d in_ready=%b, want 128 0", acc_cnt - base, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'd0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 12'd0 || out_sob !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d sob=%b, want 1 0 1", i, out_valid, out_data, out_sob);
      end
    end
    drain(128, 400);
    vectors++;
    if (obs_q.size() != 128 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain: outputs=%0d in_ready=%b, want 128 1", obs_q.size(), in_ready);
    end
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        miscompares++;
        $display("FAIL bp[%0d]: got d=%0d sob=%b eob=%b, want d=%0d sob=%b eob=%b",
                 k, o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
  endtask

  task automatic test_random_stalls();
    ent_t o, e;
    int base = acc_cnt;
    int n;
    for (int i = 0; i < 12000 && acc_cnt - base < 1280; i++)
      step(1'($urandom), 12'($urandom), 1'($urandom));
    vectors++;
    if (acc_cnt - base != 1280) begin
      miscompares++;
      $display("FAIL rand_accept: accepted %0d, want 1280", acc_cnt - base);
    end
    n = exp_q.size();
    drain(n, 3000);
    vectors++;
    if (obs_q.size() != n) begin
      miscompares++;
      $display("FAIL rand_count: got %0d outputs, want %0d", obs_q.size(), n);
    end
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        miscompares++;
        $display("FAIL rand[%0d]: got d=%0d sob=%b eob=%b, want d=%0d sob=%b eob=%b",
                 k, o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
  endtask

  task automatic test_mid_block_reset();
    ent_t o, e;
    for (int i = 0; i < 94; i++) step(1'b1, 12'($urandom), 1'b1);
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL mrst_pre: got 0 outputs before reset, want >0");
    end
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        miscompares++;
        $display("FAIL mrst_pre[%0d]: got d=%0d, want d=%0d", k, o.d, e.d);
      end
    end
    rst = 1'b1;
    step(1'b1, 12'd0, 1'b0);
    rst = 1'b0;
    cnt = 0; exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 12'd0, 1'b1);
    vectors++;
    if (obs_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mrst_stop: outputs=%0d out_valid=%b in_ready=%b, want 0 0 1",
               obs_q.size(), out_valid, in_ready);
    end
    for (int i = 0; i < 64; i++) step(1'b1, 12'(i), 1'b1);
    drain(64, 200);
    vectors++;
    if (obs_q.size() != 64) begin
      miscompares++;
      $display("FAIL mrst_count: got %0d outputs, want 64", obs_q.size());
    end
    for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        miscompares++;
        $display("FAIL mrst_post[%0d]: got d=%0d sob=%b eob=%b, want d=%0d sob=%b eob=%b",
                 k, o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
  endtask

  initial begin
    build_zz();
    @(negedge clk);
    test_reset();
    test_zigzag();
    test_back_to_back();
    test_backpressure();
    test_random_stalls();
    test_mid_block_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
